// File: rtl/arb_pkg.sv
// Shared types and helpers for the N-channel round-robin stream arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    FLUSH = 2'd2
  } arb_state_e;

  // A channel whose mode equals this value is not requesting.
  localparam int unsigned MODE_OFF = 0;

  // Index width that stays at least one bit wide for tiny channel counts.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational grant picker: first requester at or after ptr, wrapping.
// With ARB_FIXED_PRIO_EN defined the pointer is ignored and the lowest index wins.
module rr_pick #(
  parameter int NCH = 4,
  parameter int IW  = arb_pkg::idx_w(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic           valid,
  output logic [IW-1:0]  idx
);

`ifdef ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end
`else
  always_comb begin
    logic found;
    valid = |req;
    idx   = '0;
    found = 1'b0;
    // Upper segment [ptr..NCH-1] first, then wrap to [0..ptr-1].
    for (int i = 0; i < NCH; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (!found && req[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/arbiter_rr_n.sv
// N-channel pixel-stream arbiter: round-robin grants, burst limit, FIFO backpressure, flush.
// Build with ARB_FIXED_PRIO_EN to switch the picker to fixed lowest-index priority.
module arbiter_rr_n
  import arb_pkg::*;
#(
  parameter  int NCH       = 4,
  parameter  int DW        = 32,
  parameter  int MW        = 2,
  parameter  int BURST_MAX = 16,
  localparam int IW        = idx_w(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*MW-1:0] slv_mode,
  input  logic [NCH*DW-1:0] slv_data,
  input  logic [NCH-1:0]    slv_data_valid,
  input  logic [NCH-1:0]    slv_proc_valid,
  output logic [NCH-1:0]    slv_ready,
  input  logic              fifo_full,
  input  logic              mstr_cmplt,
  output logic [MW-1:0]     slvx_mode,
  output logic [DW-1:0]     slvx_data,
  output logic              slvx_data_valid,
  output logic              slvx_proc_val,
  output logic [IW-1:0]     data_source
);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [MW-1:0] mode_q, mode_d;
  logic [DW-1:0] data_q, data_d;
  logic          dv_q, dv_d;
  logic          pv_q, pv_d;

  logic [NCH-1:0] req;
  logic [MW-1:0]  g_mode;
  logic [DW-1:0]  g_data;
  logic           g_dv, g_pv;
  logic           in_gnt, ready_on, beat, burst_done, rel;
  logic [7:0]     cnt_inc;
  logic [IW-1:0]  nxt_ptr, pick_ptr, pick_idx;
  logic           pick_vld;

  for (genvar i = 0; i < NCH; i++) begin : g_req
    assign req[i] = (slv_mode[i*MW +: MW] != MW'(MODE_OFF));
  end

  assign g_mode = slv_mode[int'(gnt_q)*MW +: MW];
  assign g_data = slv_data[int'(gnt_q)*DW +: DW];
  assign g_dv   = slv_data_valid[gnt_q];
  assign g_pv   = slv_proc_valid[gnt_q];

  assign in_gnt     = (state_q == GRANT);
  assign ready_on   = in_gnt && !fifo_full && !mstr_cmplt;
  assign slv_ready  = ready_on ? (NCH'(1) << gnt_q) : '0;
  assign beat       = ready_on && g_dv;
  assign cnt_inc    = cnt_q + 8'd1;
  assign burst_done = beat && (cnt_inc == 8'(BURST_MAX));
  assign rel        = in_gnt && ((g_mode == MW'(MODE_OFF)) || burst_done);

  // On release the search restarts just past the outgoing grantee, in the same cycle.
  assign nxt_ptr  = (gnt_q == IW'(NCH - 1)) ? '0 : gnt_q + 1'b1;
  assign pick_ptr = in_gnt ? nxt_ptr : ptr_q;

  rr_pick #(.NCH(NCH), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      pv_q    <= pv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (mstr_cmplt) begin
      state_d = FLUSH;
      gnt_d   = '0;
      ptr_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            gnt_d   = pick_idx;
            state_d = GRANT;
          end
        end
        GRANT: begin
          if (beat) cnt_d = cnt_inc;
          if (rel) begin
            ptr_d = nxt_ptr;
            cnt_d = '0;
            if (pick_vld) gnt_d = pick_idx;
            else          state_d = IDLE;
          end
        end
        FLUSH:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Mode and proc-valid hold across empty cycles; data and valid clear.
  always_comb begin
    dv_d   = beat;
    data_d = beat ? g_data : '0;
    mode_d = beat ? g_mode : mode_q;
    pv_d   = beat ? g_pv   : pv_q;
    if (mstr_cmplt || (state_q == FLUSH)) begin
      dv_d   = 1'b0;
      data_d = '0;
      mode_d = '0;
      pv_d   = 1'b0;
    end
  end

  assign slvx_mode       = mode_q;
  assign slvx_data       = data_q;
  assign slvx_data_valid = dv_q;
  assign slvx_proc_val   = pv_q;
  assign data_source     = gnt_q;

endmodule

// File: tb/tb_arbiter_rr_n.sv
// Directed + random bench for arbiter_rr_n against a cycle-level behavioural model.
module tb_arbiter_rr_n;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int MW  = 2;
  localparam int BM  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH*MW-1:0] slv_mode;
  logic [NCH*DW-1:0] slv_data;
  logic [NCH-1:0]    slv_data_valid, slv_proc_valid, slv_ready;
  logic              fifo_full, mstr_cmplt;
  logic [MW-1:0]     slvx_mode;
  logic [DW-1:0]     slvx_data;
  logic              slvx_data_valid, slvx_proc_val;
  logic [1:0]        data_source;

  arbiter_rr_n #(.NCH(NCH), .DW(DW), .MW(MW), .BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst), .slv_mode(slv_mode), .slv_data(slv_data),
    .slv_data_valid(slv_data_valid), .slv_proc_valid(slv_proc_valid),
    .slv_ready(slv_ready), .fifo_full(fifo_full), .mstr_cmplt(mstr_cmplt),
    .slvx_mode(slvx_mode), .slvx_data(slvx_data), .slvx_data_valid(slvx_data_valid),
    .slvx_proc_val(slvx_proc_val), .data_source(data_source)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: granted flag/flushing flag, grantee, beats in burst, search start.
  bit          m_granted, m_flush;
  int          m_g, m_cnt, m_ptr;
  logic [1:0]  m_mode;
  logic [31:0] m_data;
  logic        m_dv, m_pv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit wants(int i);
    return slv_mode[i*MW +: MW] != 2'd0;
  endfunction

  function automatic int pick(int from);
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < NCH; i++) if (wants(i)) return i;
`else
    for (int k = 0; k < NCH; k++) if (wants((from + k) % NCH)) return (from + k) % NCH;
`endif
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] rdy);
    int p;
    bit beat;
    if (rst || mstr_cmplt) begin
      m_granted = 0; m_flush = !rst; m_g = 0; m_cnt = 0; m_ptr = 0;
      m_mode = 0; m_data = 0; m_dv = 0; m_pv = 0;
      return;
    end
    beat = rdy[m_g] && slv_data_valid[m_g];
    m_dv = beat;
    if (beat) begin
      m_mode = slv_mode[m_g*MW +: MW];
      m_data = slv_data[m_g*DW +: DW];
      m_pv   = slv_proc_valid[m_g];
    end else m_data = 0;
    if (m_flush) m_flush = 0;
    else if (!m_granted) begin
      p = pick(m_ptr);
      if (p >= 0) begin m_g = p; m_granted = 1; end
    end else begin
      if (beat) m_cnt++;
      if (!wants(m_g) || m_cnt == BM) begin
        m_ptr = (m_g + 1) % NCH;
        m_cnt = 0;
        p = pick(m_ptr);
        if (p >= 0) m_g = p; else m_granted = 0;
      end
    end
  endtask

  task automatic cycle();
    logic [3:0] rexp;
    @(negedge clk);
    rexp = (m_granted && !m_flush && !fifo_full && !mstr_cmplt) ? 4'(1 << m_g) : 4'b0;
    chk("slv_ready", 64'(slv_ready), 64'(rexp));
    @(posedge clk);
    model_step(rexp);
    #1;
    chk("data_source", 64'(data_source), 64'(m_g));
    chk("slvx_data_valid", 64'(slvx_data_valid), 64'(m_dv));
    chk("slvx_data", 64'(slvx_data), 64'(m_data));
    chk("slvx_mode", 64'(slvx_mode), 64'(m_mode));
    chk("slvx_proc_val", 64'(slvx_proc_val), 64'(m_pv));
  endtask

  task automatic rand_data();
    for (int i = 0; i < NCH; i++) slv_data[i*DW +: DW] = $urandom;
    slv_proc_valid = 4'($urandom);
  endtask

  task automatic idle_inputs();
    slv_mode = '0; slv_data_valid = '0; fifo_full = 0; mstr_cmplt = 0; rst = 0;
  endtask

  initial begin
    int pulses, first_seen;
    int runs[$];
    idle_inputs();
    rst = 1;
    slv_data = '0; slv_proc_valid = '0;
    m_granted = 0; m_flush = 0; m_g = 0; m_cnt = 0; m_ptr = 0;
    m_mode = 0; m_data = 0; m_dv = 0; m_pv = 0;
    repeat (2) cycle();
    chk("reset_valid", 64'(slvx_data_valid), 64'd0);
    chk("reset_src", 64'(data_source), 64'd0);
    rst = 0;

    // ch1 and ch3 stream continuously: alternating 4-beat grants, no bubbles.
    slv_mode = 8'b01_00_01_00; slv_data_valid = 4'hF;
    pulses = 0;
    for (int k = 0; k < 34; k++) begin
      rand_data();
      cycle();
      if (slvx_data_valid) pulses++;
      if (runs.size() == 0 || runs[$] != int'(data_source)) runs.push_back(int'(data_source));
    end
    chk("t1_pulses", 64'(pulses), 64'd33);
`ifndef ARB_FIXED_PRIO_EN
    chk("t1_run0", 64'(runs[0]), 64'd1);
    chk("t1_run1", 64'(runs[1]), 64'd3);
    chk("t1_run2", 64'(runs[2]), 64'd1);
    chk("t1_run3", 64'(runs[3]), 64'd3);
`endif
    idle_inputs();
    repeat (3) cycle();

    // ch2 alone, 6 beats, FIFO full on cycles 3-4 of the run.
    slv_mode = 8'b00_01_00_00; slv_data_valid = 4'b0100;
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      fifo_full = (k == 3 || k == 4);
      rand_data();
      cycle();
      if (slvx_data_valid) pulses++;
      if (pulses == 6) begin slv_data_valid = '0; slv_mode = '0; end
    end
    chk("t2_pulses", 64'(pulses), 64'd6);
    idle_inputs();
    repeat (2) cycle();

    // ch0 mid-burst, one-cycle master-complete pulse.
    slv_mode = 8'b00_00_00_10; slv_data_valid = 4'b0001;
    repeat (3) begin rand_data(); cycle(); end
    mstr_cmplt = 1;
    cycle();
    chk("t3_flush_valid", 64'(slvx_data_valid), 64'd0);
    chk("t3_flush_mode", 64'(slvx_mode), 64'd0);
    mstr_cmplt = 0;
    first_seen = 0;
    for (int k = 0; k < 4; k++) begin
      rand_data(); cycle();
      if (slvx_data_valid && first_seen == 0) first_seen = k;
    end
    chk("t3_regrant_src", 64'(data_source), 64'd0);
    chk("t3_first_beat_cycle", 64'(first_seen), 64'd2);
    idle_inputs();
    repeat (2) cycle();

    // Pointer lands on 3 when ch2 drops; everyone else requesting.
    slv_mode = 8'b00_01_00_00; slv_data_valid = 4'b0000;
    repeat (2) cycle();
    slv_mode = 8'b01_00_01_01; slv_data_valid = 4'hF;
    cycle();
`ifndef ARB_FIXED_PRIO_EN
    chk("t4_first", 64'(data_source), 64'd3);
`endif
    slv_mode = 8'b01_01_01_01;
    repeat (4) begin rand_data(); cycle(); end
`ifndef ARB_FIXED_PRIO_EN
    chk("t4_wrap", 64'(data_source), 64'd0);
`endif

    // Reset lands on a burst in progress.
    rand_data(); cycle();
    rst = 1;
    rand_data(); cycle();
    chk("t6_valid", 64'(slvx_data_valid), 64'd0);
    chk("t6_src", 64'(data_source), 64'd0);
    rst = 0;

    // Random traffic; modes change occasionally so bursts form.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(7) == 0) begin
        slv_mode = 8'($urandom);
        for (int i = 0; i < NCH; i++) if ($urandom_range(1) == 0) slv_mode[i*MW +: MW] = 2'd0;
      end
      slv_data_valid = 4'($urandom);
      fifo_full  = ($urandom_range(4) == 0);
      mstr_cmplt = ($urandom_range(39) == 0);
      rst        = ($urandom_range(96) == 0);
      rand_data();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arbiter_rr_n.md
Name: arbiter_rr_n

Overview:
N-channel, parametrised successor to the two-slave mode arbiter. It merges NCH pixel-stream slaves onto one registered output stream that feeds the downstream FIFO. Grants are round-robin, with per-grant burst limiting, FIFO backpressure and master-complete flush. It sits between the slave DMA/filter ports and the processing FIFO.

Parameters:
NCH, 4, number of slave channels (2..16)
DW, 32, data width per channel
MW, 2, mode field width; mode 0 = channel inactive
BURST_MAX, 16, max beats per grant before forced rotation (1..255)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
slv_mode  in  NCH*MW  per-channel mode, channel i at [i*MW +: MW]
slv_data  in  NCH*DW  per-channel data
slv_data_valid  in  NCH  per-channel data valid
slv_proc_valid  in  NCH  per-channel process-valid flag
slv_ready  out  NCH  one-hot ready to granted channel
fifo_full  in  1  downstream FIFO full
mstr_cmplt  in  1  master transaction complete; flush request
slvx_mode  out  MW  registered mode of forwarded beat
slvx_data  out  DW  registered data
slvx_data_valid  out  1  registered valid
slvx_proc_val  out  1  registered proc-valid
data_source  out  $clog2(NCH)  index of currently granted channel

Behaviour:
- Reset (rst=1 at posedge): state IDLE; all outputs 0; rr pointer 0; beat counter 0.
- Channel i requests when slv_mode[i] != 0.
- States: IDLE, GRANT, FLUSH.
- IDLE: if any request and !mstr_cmplt, pick the first requester at or after ptr (wrapping from NCH-1 to 0); latch grant index into data_source; go to GRANT next cycle. No request: stay in IDLE, slvx_data_valid=0.
- GRANT: slv_ready[g] = !fifo_full && !mstr_cmplt. This is combinational from registered state; all other ready bits are 0.
- Beat: a beat transfers when slv_ready[g] && slv_data_valid[g]. On the next cycle, slvx_* = channel g's mode/data/proc_valid and slvx_data_valid=1. Latency is one cycle.
- No beat in a cycle: slvx_data_valid=0 and slvx_data=0 next cycle. slvx_mode/proc_val hold.
- Beat counter increments per beat.
- Release grant when any of these holds: slv_mode[g]==0; counter reaches BURST_MAX on this beat; mstr_cmplt.
- On release: ptr = g+1 mod NCH, counter cleared. Rearbitrate in the same cycle: a new grant is registered at that edge, so there are no idle cycles between grants. If no requester, go to IDLE.
- fifo_full: ready drops in the same cycle. Grant and counter hold; the burst resumes when full clears. Does not count as a beat.
- mstr_cmplt in any state: next cycle go to FLUSH. In FLUSH all slv_ready=0, slvx_* = 0, data_source=0, ptr=0. Stay in FLUSH while mstr_cmplt=1; go to IDLE the cycle after it drops.
- Simultaneous beat and mstr_cmplt: impossible, since ready is gated by !mstr_cmplt.
- Simultaneous release and fifo_full: release is still taken; the new grantee sees ready=0 until full clears.
- Single requester: it is regranted after each BURST_MAX rotation, with no bubble.
- rst mid-burst: the in-flight beat is discarded; outputs are 0 on the next cycle.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: the pick ignores ptr and always selects the lowest-index requester. BURST_MAX still forces release, but channel 0 may be regranted immediately.
- Undefined: round-robin as above.

Decomposition:
- Package arb_pkg: state enum arb_state_e {IDLE, GRANT, FLUSH}; localparam MODE_OFF = '0; function clog2-safe index width.
- Sub-module rr_pick (NCH): inputs req[NCH] and ptr; outputs valid and idx. It is purely combinational. It is the only place the ARB_FIXED_PRIO_EN macro is tested.

Test Plan:
- NCH=4, BURST_MAX=4, ch1 and ch3 request continuously with valid=1 -> data_source sequence 1,3,1,3, with 4 beats each and no idle cycle between grants.
- ch2 only, 6 beats, fifo_full=1 for cycles 3-4 -> slv_ready[2] low in those cycles; exactly 6 slvx_data_valid pulses with data order preserved.
- ch0 mid-burst, mstr_cmplt pulsed 1 cycle -> next cycle FLUSH with all outputs 0; IDLE after; ch0 regrant starts with ptr=0.
- All channels request, ptr=3 -> first grant ch3, then wraps to ch0.
- ARB_FIXED_PRIO_EN defined, ch0 and ch2 request, BURST_MAX=2 -> ch0 wins every arbitration and ch2 never granted while ch0's mode != 0.
- rst asserted during beat 2 of a burst -> next cycle slvx_data_valid=0, slv_ready=0, data_source=0.
